dvp_stream_tx: RTL and testbench
================================

Name: dvp_stream_tx

Overview:
- Generates an OV7670-style DVP byte stream (oVSYNC, oHREF, 8-bit data) from a 16-bit YCbCr 4:2:2 pixel source.
- It is the transmit end of the camera capture path: its output drives the capture/decoder input directly.
- Used as a camera emulator for bench and board loopback tests, and to stream frame-buffer contents to a second DVP sink.
- One output byte per iCLK cycle; iCLK doubles as the DVP pixel-byte clock.

Parameters:
- H_ACTIVE, 640: active pixels per line; each pixel is sent as 2 bytes.
- V_ACTIVE, 480: active lines per frame.
- H_BLANK, 144: HREF-low cycles after each line's active bytes.
- VSYNC_LEN, 3: lines with oVSYNC high.
- V_BACK, 17: blank lines after VSYNC, before the first active line.
- V_FRONT, 10: blank lines after the last active line.

Ports:
- iCLK, in, 1: clock; one byte slot per cycle.
- iRST, in, 1: synchronous reset, active-high.
- iEN, in, 1: frame enable, sampled only at frame boundaries.
- iPIX_DATA, in, 16: pixel word {C[7:0], Y[7:0]}; C alternates Cb (even pixel) and Cr (odd pixel), as supplied by the source.
- iPIX_VALID, in, 1: iPIX_DATA is valid.
- oPIX_READY, out, 1: block consumes iPIX_DATA at this rising edge.
- oDATA, out, 8: DVP data byte.
- oHREF, out, 1: line-valid, active high.
- oVSYNC, out, 1: frame sync, active high.
- oFrame_Cont, out, 16: completed-frame count; wraps at 0xFFFF.
- oUNDERFLOW, out, 1: sticky; source was not valid when a pixel was required.

Behaviour:
- Reset: iRST=1 at an edge puts the block in IDLE on the next cycle. oDATA=0, oHREF=0, oVSYNC=0, oFrame_Cont=0, oUNDERFLOW=0; all counters cleared. Reset mid-frame aborts the frame immediately; no partial line completes.
- Timing counters:
  - LINE_LEN = 2*H_ACTIVE + H_BLANK.
  - hcnt runs 0..LINE_LEN-1 and wraps, incrementing vcnt.
  - FRAME_LINES = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT.
- FSM states (line granularity; transitions taken when hcnt wraps):
  - IDLE: outputs low. If iEN=1, go to VSYNC with hcnt=0 and vcnt=0.
  - VSYNC: oVSYNC=1 for VSYNC_LEN full lines, then V_BACK.
  - V_BACK: all low for V_BACK lines, then ACTIVE.
  - ACTIVE:
    - hcnt < 2*H_ACTIVE: oHREF=1, bytes are C then Y of each pixel in turn.
    - Remainder of the line: oHREF=0, oDATA=0.
    - After V_ACTIVE lines, go to V_FRONT.
  - V_FRONT: all low for V_FRONT lines. At the last cycle, oFrame_Cont increments. Then go to VSYNC if iEN=1, else IDLE; there are no gap cycles between back-to-back frames.
- iEN deassertion mid-frame does not truncate the frame.
- Zero-length V_BACK/V_FRONT values are not supported (parameter minimum is 1).
- oDATA, oHREF and oVSYNC are registered. oPIX_READY is decoded from registered state and counters only; it has no combinational path from iPIX_VALID.
- Pixel handshake:
  - oPIX_READY=1 in the cycle before each pixel's C-byte slot: once at hcnt = LINE_LEN-1 of the previous line (or the last cycle of V_BACK), then on every second cycle until H_ACTIVE words have been requested.
  - Word captured at edge t: C appears on oDATA at t+1 and Y at t+2 (latency 1).
  - Exactly H_ACTIVE*V_ACTIVE ready pulses per frame. No ready pulses outside ACTIVE lines or in the last pixel's Y slot.
- Underflow: if oPIX_READY=1 and iPIX_VALID=0, the block emits black (C=0x80, Y=0x10) for that pixel and sets oUNDERFLOW=1 until reset. Line timing is unaffected, and the missing word is not re-requested (the source must drop it).
- Simultaneous events:
  - iRST dominates all other inputs.
  - oFrame_Cont increments on the same edge that V_FRONT ends.

Test Plan (parameters H_ACTIVE=4, V_ACTIVE=2, H_BLANK=3, VSYNC_LEN=1, V_BACK=1, V_FRONT=1, giving LINE_LEN=11 and 55 cycles per frame):
1. Reset then iEN=1, source always valid with words 0x8001, 0x8102, 0x8203, ... → oVSYNC high for cycles 0-10. oHREF high for 8 cycles starting at cycle 22 and again at cycle 33. oDATA on line 1 = 80,01,81,02,82,03,83,04.
2. Same run → exactly 8 oPIX_READY pulses per frame, the first at cycle 21. oFrame_Cont=1 after cycle 54. With iEN held, oVSYNC rises again at cycle 55.
3. iPIX_VALID=0 at the 3rd ready pulse → that pixel is output as 80,10; oUNDERFLOW=1 and stays 1. oHREF waveform is identical to scenario 1.
4. iEN dropped during line 3 → frame completes, oFrame_Cont=1, block returns to IDLE with all outputs 0. Re-asserting iEN starts a new frame with oVSYNC high on the next cycle.
5. iRST pulsed for one cycle while oHREF=1 → next cycle all outputs 0 and oUNDERFLOW=0. With iEN=1, oVSYNC=1 follows the cycle after iRST returns low.
6. Loopback into the capture decoder at default parameters → decoder reports 640×480 with the pixel data matching the source pattern.

Source files
------------

// File: rtl/dvp_stream_tx.sv
// OV7670-style DVP transmitter: turns a 16-bit YCbCr 4:2:2 pixel stream into
// VSYNC/HREF/byte timing, one byte per clock, requesting one pixel word per two bytes.
module dvp_stream_tx #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned H_BLANK   = 144,
    parameter int unsigned VSYNC_LEN = 3,
    parameter int unsigned V_BACK    = 17,
    parameter int unsigned V_FRONT   = 10
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [15:0] iPIX_DATA,
    input  logic        iPIX_VALID,
    output logic        oPIX_READY,
    output logic [7:0]  oDATA,
    output logic        oHREF,
    output logic        oVSYNC,
    output logic [15:0] oFrame_Cont,
    output logic        oUNDERFLOW
);

    localparam int unsigned LINE_LEN    = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned FRAME_LINES = VSYNC_LEN + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned HW          = $clog2(LINE_LEN);
    localparam int unsigned VW          = $clog2(FRAME_LINES);

    localparam logic [HW-1:0] H_LAST     = HW'(LINE_LEN - 1);
    localparam logic [HW-1:0] H_ACT_END  = HW'(2 * H_ACTIVE);
    localparam logic [HW-1:0] H_RDY_END  = HW'(2 * H_ACTIVE - 2);
    localparam logic [VW-1:0] V_VS_LAST  = VW'(VSYNC_LEN - 1);
    localparam logic [VW-1:0] V_VB_LAST  = VW'(VSYNC_LEN + V_BACK - 1);
    localparam logic [VW-1:0] V_ACT_LAST = VW'(VSYNC_LEN + V_BACK + V_ACTIVE - 1);
    localparam logic [VW-1:0] V_FR_LAST  = VW'(FRAME_LINES - 1);
    localparam logic [15:0]   BLACK_PIX  = 16'h8010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBACK,
        S_ACTIVE,
        S_VFRONT
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [7:0]    r_y;
    logic [7:0]    r_data;
    logic          r_href;
    logic          r_vsync;
    logic [15:0]   r_frame_cnt;
    logic          r_underflow;

    state_t        w_state_nxt;
    logic [HW-1:0] w_hcnt_nxt;
    logic [VW-1:0] w_vcnt_nxt;
    logic          w_line_end;
    logic          w_frame_done;
    logic          w_ready;
    logic [15:0]   w_word;
    logic          w_href_nxt;
    logic [7:0]    w_data_nxt;

    // Line-granular frame sequencing plus the byte-slot decode for the next cycle.
    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_vcnt_nxt   = r_vcnt;
        w_frame_done = 1'b0;
        w_line_end   = (r_hcnt == H_LAST);
        w_ready      = 1'b0;
        w_word       = iPIX_VALID ? iPIX_DATA : BLACK_PIX;
        w_href_nxt   = 1'b0;
        w_data_nxt   = 8'h00;

        if (r_state == S_IDLE) begin
            if (iEN) begin
                w_state_nxt = S_VSYNC;
                w_hcnt_nxt  = '0;
                w_vcnt_nxt  = '0;
            end
        end else if (w_line_end) begin
            w_hcnt_nxt = '0;
            w_vcnt_nxt = r_vcnt + VW'(1);
            case (r_state)
                S_VSYNC:  if (r_vcnt == V_VS_LAST)  w_state_nxt = S_VBACK;
                S_VBACK:  if (r_vcnt == V_VB_LAST)  w_state_nxt = S_ACTIVE;
                S_ACTIVE: if (r_vcnt == V_ACT_LAST) w_state_nxt = S_VFRONT;
                S_VFRONT: begin
                    if (r_vcnt == V_FR_LAST) begin
                        w_frame_done = 1'b1;
                        w_vcnt_nxt   = '0;
                        w_state_nxt  = iEN ? S_VSYNC : S_IDLE;
                    end
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end else begin
            w_hcnt_nxt = r_hcnt + HW'(1);
        end

        // Request a word one cycle ahead of every C-byte slot.
        w_ready = ((r_state == S_VBACK) && (r_vcnt == V_VB_LAST) && w_line_end) ||
                  ((r_state == S_ACTIVE) &&
                   ((w_line_end && (r_vcnt != V_ACT_LAST)) ||
                    (r_hcnt[0] && (r_hcnt < H_RDY_END))));

        w_href_nxt = (w_state_nxt == S_ACTIVE) && (w_hcnt_nxt < H_ACT_END);
        if (w_ready) begin
            w_data_nxt = w_word[15:8];
        end else if (w_href_nxt && w_hcnt_nxt[0]) begin
            w_data_nxt = r_y;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state     <= S_IDLE;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_y         <= 8'h00;
            r_data      <= 8'h00;
            r_href      <= 1'b0;
            r_vsync     <= 1'b0;
            r_frame_cnt <= 16'h0000;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_vcnt  <= w_vcnt_nxt;
            r_data  <= w_data_nxt;
            r_href  <= w_href_nxt;
            r_vsync <= (w_state_nxt == S_VSYNC);
            if (w_ready) begin
                r_y <= w_word[7:0];
                if (!iPIX_VALID) begin
                    r_underflow <= 1'b1;
                end
            end
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign oPIX_READY  = w_ready;
    assign oDATA       = r_data;
    assign oHREF       = r_href;
    assign oVSYNC      = r_vsync;
    assign oFrame_Cont = r_frame_cnt;
    assign oUNDERFLOW  = r_underflow;

endmodule

// File: tb/tb_dvp_stream_tx.sv
// Bench for dvp_stream_tx: directed frame scenarios plus random traffic, checked
// every cycle against a frame-position model of the DVP timing and pixel payload.
module tb_dvp_stream_tx;

    localparam int H  = 4;
    localparam int VA = 2;
    localparam int HB = 3;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int LL = 2 * H + HB;
    localparam int FL = VS + VB + VA + VF;
    localparam int FC = LL * FL;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iEN = 1'b0;
    logic [15:0] iPIX_DATA = 16'h0000;
    logic        iPIX_VALID = 1'b0;
    logic        oPIX_READY;
    logic [7:0]  oDATA;
    logic        oHREF;
    logic        oVSYNC;
    logic [15:0] oFrame_Cont;
    logic        oUNDERFLOW;

    always #5 iCLK = ~iCLK;

    dvp_stream_tx #(
        .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
        .VSYNC_LEN(VS), .V_BACK(VB), .V_FRONT(VF)
    ) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN),
        .iPIX_DATA(iPIX_DATA), .iPIX_VALID(iPIX_VALID), .oPIX_READY(oPIX_READY),
        .oDATA(oDATA), .oHREF(oHREF), .oVSYNC(oVSYNC),
        .oFrame_Cont(oFrame_Cont), .oUNDERFLOW(oUNDERFLOW)
    );

    int          total = 0;
    int          bad = 0;
    int          pos = -1;           // cycle within current frame, -1 when idle
    logic [15:0] frames = 16'h0000;
    bit          uf = 1'b0;
    logic [15:0] pix [H*VA];         // words the pixel slots of this frame must carry
    bit          seq_mode = 1'b0;
    int          seq_k = 0;
    int          rdy_seen = 0;

    function automatic bit m_href(input int p);
        int line;
        int col;
        if (p < 0) return 1'b0;
        line = p / LL;
        col  = p % LL;
        return (line >= VS + VB) && (line < VS + VB + VA) && (col < 2 * H);
    endfunction

    function automatic int m_pidx(input int p);
        return ((p / LL) - VS - VB) * H + (p % LL) / 2;
    endfunction

    function automatic bit m_ready(input int p);
        if (p < 0 || p + 1 >= FC) return 1'b0;
        return m_href(p + 1) && (((p + 1) % LL) % 2 == 0);
    endfunction

    function automatic logic [7:0] m_data(input int p);
        logic [15:0] w;
        if (!m_href(p)) return 8'h00;
        w = pix[m_pidx(p)];
        return (((p % LL) % 2) == 0) ? w[15:8] : w[7:0];
    endfunction

    function automatic bit m_vsync(input int p);
        return (p >= 0) && ((p / LL) < VS);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s pos=%0d observed=%h expected=%h", tag, pos, obs, exp);
        end
    endtask

    // One clock: drive inputs, check this cycle's outputs, advance the model.
    // drop: -1 never drop, -2 drop about 1 in 8 requests, else pixel index to drop.
    task automatic step(input bit en, input bit rst, input int drop);
        bit          r;
        bit          v;
        int          p;
        logic [15:0] w;
        v    = 1'b1;
        iEN  = en;
        iRST = rst;
        r    = m_ready(pos);
        w    = seq_mode ? {8'(8'h80 + seq_k), 8'(seq_k + 1)} : 16'($urandom);
        if (r) begin
            p = m_pidx(pos + 1);
            if (drop == -1)      v = 1'b1;
            else if (drop == -2) v = ($urandom_range(7) != 0);
            else                 v = (p != drop);
            iPIX_VALID = v;
            iPIX_DATA  = w;
            pix[p]     = v ? w : 16'h8010;
            if (seq_mode) seq_k++;
        end else begin
            iPIX_VALID = 1'($urandom_range(1));
            iPIX_DATA  = 16'($urandom);
        end
        check("vsync", 16'(oVSYNC), 16'(m_vsync(pos)));
        check("href",  16'(oHREF),  16'(m_href(pos)));
        check("data",  16'(oDATA),  16'(m_data(pos)));
        check("ready", 16'(oPIX_READY), 16'(r));
        check("frame_cnt", oFrame_Cont, frames);
        check("underflow", 16'(oUNDERFLOW), 16'(uf));
        if (oPIX_READY === 1'b1) rdy_seen++;
        @(posedge iCLK);
        #1;
        if (rst) begin
            pos    = -1;
            frames = 16'h0000;
            uf     = 1'b0;
        end else begin
            if (r && !v) uf = 1'b1;
            if (pos < 0) begin
                pos = en ? 0 : -1;
            end else if (pos == FC - 1) begin
                frames = frames + 16'd1;
                pos    = en ? 0 : -1;
            end else begin
                pos++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < H * VA; i++) pix[i] = 16'h0000;
        repeat (3) @(posedge iCLK);
        #1;
        step(0, 1, -1);
        step(0, 1, -1);
        repeat (3) step(0, 0, -1);

        // Sequential pattern frame, source always valid.
        seq_mode = 1'b1;
        seq_k    = 0;
        rdy_seen = 0;
        step(1, 0, -1);
        repeat (FC) step(1, 0, -1);
        check("ready_pulses", 16'(rdy_seen), 16'd8);
        check("frames_after_1", oFrame_Cont, 16'd1);
        check("vsync_back_to_back", 16'(oVSYNC), 16'd1);

        // Random data, third requested pixel missing.
        seq_mode = 1'b0;
        repeat (FC) step(1, 0, 2);
        check("underflow_sticky", 16'(oUNDERFLOW), 16'd1);

        // Enable dropped during line 3: frame still completes, then idle.
        repeat (3 * LL) step(1, 0, -1);
        repeat (FC - 3 * LL) step(0, 0, -1);
        repeat (4) step(0, 0, -1);
        check("frames_after_3", oFrame_Cont, 16'd3);
        check("idle_href", 16'(oHREF), 16'd0);
        step(1, 0, -1);
        check("restart_vsync", 16'(oVSYNC), 16'd1);

        // Reset pulse in the middle of an active line.
        repeat (25) step(1, 0, -1);
        check("href_before_rst", 16'(oHREF), 16'd1);
        step(1, 1, -1);
        check("rst_underflow", 16'(oUNDERFLOW), 16'd0);
        check("rst_frames", oFrame_Cont, 16'd0);
        step(1, 0, -1);
        check("vsync_after_rst", 16'(oVSYNC), 16'd1);

        // Random enable and random source stalls.
        for (int i = 0; i < 5 * FC; i++) begin
            step(($urandom_range(3) != 0), 1'b0, -2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
